// File: rtl/modulo_down_counter.sv
// Loadable, enable-gated modulo down-counter with one-shot / auto-reload modes.
// Counts from a loaded value toward zero, pulses tc for one cycle at the terminal
// event and exposes a combinational borrow for cascading into the next stage's en.
module modulo_down_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             borrow_out
);

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   ModWide   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ReloadVal = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] loadClamped;

    // Out-of-range load values saturate to the top of the count range.
    always_comb begin
        loadClamped = load_val;
        if ({1'b0, load_val} >= ModWide) begin
            loadClamped = ReloadVal;
        end
    end

    // State, count and registered flags; load overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            q     <= '0;
            busy  <= 1'b0;
            tc    <= 1'b0;
        end else if (load) begin
            state <= StRun;
            q     <= loadClamped;
            busy  <= 1'b1;
            tc    <= 1'b0;
        end else begin
            case (state)
                StRun: begin
                    if (en && (q == '0)) begin
                        // Terminal event: mode is sampled only here.
                        tc <= 1'b1;
                        if (mode) begin
                            q <= ReloadVal;
                        end else begin
                            state <= StDone;
                            busy  <= 1'b0;
                        end
                    end else if (en) begin
                        q  <= q - 1'b1;
                        tc <= 1'b0;
                    end else begin
                        tc <= 1'b0;
                    end
                end
                StIdle, StDone: begin
                    busy <= 1'b0;
                    tc   <= 1'b0;
                end
                default: begin
                    // Unused encoding recovers to idle.
                    state <= StIdle;
                    q     <= '0;
                    busy  <= 1'b0;
                    tc    <= 1'b0;
                end
            endcase
        end
    end

    // Cascade enable: this stage is about to borrow; deliberately independent of load.
    assign borrow_out = (state == StRun) & en & (q == '0);

endmodule

// File: tb/tb_modulo_down_counter.sv
// Scoreboard bench for modulo_down_counter: directed vectors push hand-computed
// post-edge expectations, a monitor pops and compares them; side checks cover
// clamping (MODULUS=6), a two-stage cascade and asynchronous reset.
module tb_modulo_down_counter;

    typedef struct {
        int       idx;
        logic [2:0] q;
        logic     busy;
        logic     tc;
        logic     bo;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Main DUT, MODULUS=8
    logic       ld = 1'b0, md = 1'b0, en = 1'b0;
    logic [2:0] lv = 3'd0;
    logic [2:0] q;
    logic       busy, tc, bo;

    // Clamp DUT, MODULUS=6
    logic       ld6 = 1'b0, md6 = 1'b0, en6 = 1'b0;
    logic [2:0] lv6 = 3'd0;
    logic [2:0] q6;
    logic       busy6, tc6, bo6;

    // Cascade pair
    logic       cLd = 1'b0, cEn = 1'b0;
    logic [2:0] cLv = 3'd0;
    logic [2:0] lowQ, upQ;
    logic       lowBusy, lowTc, lowBo, upBusy, upTc, upBo;

    exp_t expQ[$];

    always #5 clk = ~clk;

    modulo_down_counter #(.WIDTH(3), .MODULUS(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(ld), .load_val(lv), .mode(md),
        .q(q), .busy(busy), .tc(tc), .borrow_out(bo)
    );

    modulo_down_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en6), .load(ld6), .load_val(lv6), .mode(md6),
        .q(q6), .busy(busy6), .tc(tc6), .borrow_out(bo6)
    );

    modulo_down_counter #(.WIDTH(3), .MODULUS(8)) lowStage (
        .clk(clk), .rst_n(rst_n), .en(cEn), .load(cLd), .load_val(cLv), .mode(1'b1),
        .q(lowQ), .busy(lowBusy), .tc(lowTc), .borrow_out(lowBo)
    );

    modulo_down_counter #(.WIDTH(3), .MODULUS(8)) upStage (
        .clk(clk), .rst_n(rst_n), .en(lowBo), .load(cLd), .load_val(cLv), .mode(1'b1),
        .q(upQ), .busy(upBusy), .tc(upTc), .borrow_out(upBo)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Apply one vector at the falling edge and queue the state expected after the next rise.
    task automatic step(input logic sLd, input logic [2:0] sLv, input logic sMd, input logic sEn,
                        input logic [2:0] eQ, input logic eB, input logic eT, input logic eBo);
        exp_t e;
        @(negedge clk);
        ld = sLd; lv = sLv; md = sMd; en = sEn;
        e.idx = total; e.q = eQ; e.busy = eB; e.tc = eT; e.bo = eBo;
        expQ.push_back(e);
    endtask

    task automatic tick6(input logic sLd, input logic [2:0] sLv, input logic sMd,
                         input logic sEn);
        @(negedge clk);
        ld6 = sLd; lv6 = sLv; md6 = sMd; en6 = sEn;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against queued expectations just after each rising edge.
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check($sformatf("v%0d.q", n), int'(q), int'(e.q));
                check($sformatf("v%0d.busy", n), int'(busy), int'(e.busy));
                check($sformatf("v%0d.tc", n), int'(tc), int'(e.tc));
                check($sformatf("v%0d.borrow", n), int'(bo), int'(e.bo));
                n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        #12;
        check("reset.q", int'(q), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.tc", int'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        //     ld  lv    md    en     q    b     t     bo
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); // idle ignores en
        step(1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0); // one-shot load 3
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0); // terminal -> done, tc
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); // auto-reload load 1
        step(1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0); // wrap, tc
        for (int i = 6; i >= 1; i--) begin
            step(1'b0, 3'd0, 1'b1, 1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0); // 8 cycles later
        step(1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1); // load 0
        step(1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0); // load beats terminal
        step(1'b0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0); // enable gaps
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0); // en low: no borrow
        step(1'b0, 3'd0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0); // mode changed mid-count
        step(1'b1, 3'd5, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        ld = 1'b0; en = 1'b0;

        w = 0;
        while (expQ.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #2;
        check("scoreboard.drained", expQ.size(), 0);

        // Clamp and wrap with MODULUS=6
        tick6(1'b1, 3'd7, 1'b0, 1'b0);
        check("m6.clamp7", int'(q6), 5);
        check("m6.busy", int'(busy6), 1);
        tick6(1'b1, 3'd6, 1'b0, 1'b0);
        check("m6.clamp6", int'(q6), 5);
        tick6(1'b1, 3'd0, 1'b1, 1'b1);
        check("m6.load0", int'(q6), 0);
        tick6(1'b0, 3'd0, 1'b1, 1'b1);
        check("m6.wrap", int'(q6), 5);
        check("m6.tc", int'(tc6), 1);
        tick6(1'b0, 3'd0, 1'b1, 1'b1);
        check("m6.dec", int'(q6), 4);
        check("m6.tc_off", int'(tc6), 0);

        // Cascade: both load 7, lower counts continuously
        @(negedge clk);
        cLd = 1'b1; cLv = 3'd7; cEn = 1'b0;
        @(negedge clk);
        cLd = 1'b0; cEn = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("casc.low7", int'(lowQ), 0);
        check("casc.up7", int'(upQ), 7);
        @(posedge clk);
        #1;
        check("casc.low8", int'(lowQ), 7);
        check("casc.up8", int'(upQ), 6);
        repeat (8) @(posedge clk);
        #1;
        check("casc.low16", int'(lowQ), 7);
        check("casc.up16", int'(upQ), 5);
        @(negedge clk);
        cEn = 1'b0;

        // Asynchronous reset mid-count at q=5, checked before any clock edge
        @(negedge clk);
        check("pre_reset.q", int'(q), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.q", int'(q), 0);
        check("async_reset.busy", int'(busy), 0);
        check("async_reset.tc", int'(tc), 0);
        check("async_reset.borrow", int'(bo), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
